// File: rtl/hbm_rdata_demux.sv
// HBM R-channel receiver: steers beats by RID into A/B first-word-fall-through FIFOs and flags run completion.
// Define HBM_RDATA_ERR_CNT_EN to build the RID/RRESP/RLAST checkers and their error counters.

module hbm_rdata_fifo #(
  parameter int W     = 256,
  parameter int DEPTH = 64,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          ready,
  output logic          valid,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;

  assign valid = (count != '0);
  assign pop   = valid & ready;
  assign rdata = valid ? mem[rd_ptr] : '0;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end
endmodule

// state | meaning
// IDLE  | not armed, RREADY low
// RUN   | accepting beats, waiting for beat total and drained FIFOs
// DONE  | rd_data_done high, still accepting stray beats
module hbm_rdata_demux #(
  parameter int                  DATA_WIDTH = 256,
  parameter int                  ID_WIDTH   = 6,
  parameter logic [ID_WIDTH-1:0] B_TAG      = 6'h1,
  parameter logic [ID_WIDTH-1:0] A_TAG      = 6'h2,
  parameter int                  BURST_LEN  = 4,
  parameter int                  FIFO_DEPTH = 64
) (
  input  logic                  hbm_clk,
  input  logic                  hbm_reset,
  input  logic                  start,
  input  logic [31:0]           expected_beats,
  output logic                  rd_data_done,
  input  logic                  m_axi_RVALID,
  output logic                  m_axi_RREADY,
  input  logic [DATA_WIDTH-1:0] m_axi_RDATA,
  input  logic [ID_WIDTH-1:0]   m_axi_RID,
  input  logic [1:0]            m_axi_RRESP,
  input  logic                  m_axi_RLAST,
  output logic                  b_data_valid,
  input  logic                  b_data_ready,
  output logic [DATA_WIDTH-1:0] b_data,
  output logic                  a_data_valid,
  input  logic                  a_data_ready,
  output logic [DATA_WIDTH-1:0] a_data,
  output logic [31:0]           beat_cnt,
  output logic [15:0]           err_id_cnt,
  output logic [15:0]           err_resp_cnt,
  output logic [15:0]           err_last_cnt
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state;
  logic          start_q;
  logic          start_edge;
  logic [31:0]   exp_beats_q;
  logic          accept;
  logic          push_a;
  logic          push_b;
  logic [CW-1:0] a_count;
  logic [CW-1:0] b_count;

  assign start_edge   = start & ~start_q;
  // Registered counts only: a same-cycle pop never frees room for this cycle's accept.
  assign m_axi_RREADY = (state != ST_IDLE) && (a_count < FULL_CNT) && (b_count < FULL_CNT);
  assign accept       = m_axi_RVALID & m_axi_RREADY;
  assign push_b       = accept && (m_axi_RID == B_TAG);
  assign push_a       = accept && (m_axi_RID == A_TAG);
  assign rd_data_done = (state == ST_DONE);

  hbm_rdata_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo_b (
    .clk(hbm_clk), .rst(hbm_reset), .push(push_b), .wdata(m_axi_RDATA),
    .ready(b_data_ready), .valid(b_data_valid), .rdata(b_data), .count(b_count)
  );

  hbm_rdata_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo_a (
    .clk(hbm_clk), .rst(hbm_reset), .push(push_a), .wdata(m_axi_RDATA),
    .ready(a_data_ready), .valid(a_data_valid), .rdata(a_data), .count(a_count)
  );

  always_ff @(posedge hbm_clk) begin
    if (hbm_reset) begin
      state       <= ST_IDLE;
      start_q     <= 1'b0;
      exp_beats_q <= '0;
      beat_cnt    <= '0;
    end else begin
      start_q <= start;
      if (start_edge) begin
        exp_beats_q <= expected_beats;
        beat_cnt    <= {31'd0, accept};
        state       <= ST_RUN;
      end else begin
        if (accept) beat_cnt <= beat_cnt + 32'd1;
        if (state == ST_RUN && beat_cnt == exp_beats_q &&
            a_count == '0 && b_count == '0)
          state <= ST_DONE;
      end
    end
  end

`ifdef HBM_RDATA_ERR_CNT_EN
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(BURST_LEN - 1);

  logic [BW-1:0] burst_idx;
  logic          idx_last;
  logic          id_bad;
  logic          unused_sink;

  assign idx_last    = (burst_idx == LAST_IDX);
  assign id_bad      = (m_axi_RID != B_TAG) && (m_axi_RID != A_TAG);
  assign unused_sink = 1'b0;

  // One shared position counter: reads return in order, one ID at a time.
  always_ff @(posedge hbm_clk) begin
    if (hbm_reset) begin
      burst_idx    <= '0;
      err_id_cnt   <= '0;
      err_resp_cnt <= '0;
      err_last_cnt <= '0;
    end else begin
      if (accept) burst_idx <= (m_axi_RLAST || idx_last) ? '0 : burst_idx + BW'(1);
      if (start_edge) begin
        err_id_cnt   <= '0;
        err_resp_cnt <= '0;
        err_last_cnt <= '0;
      end else if (accept) begin
        if (id_bad && err_id_cnt != 16'hFFFF) err_id_cnt <= err_id_cnt + 16'd1;
        if (m_axi_RRESP != 2'b00 && err_resp_cnt != 16'hFFFF)
          err_resp_cnt <= err_resp_cnt + 16'd1;
        if ((m_axi_RLAST != idx_last) && err_last_cnt != 16'hFFFF)
          err_last_cnt <= err_last_cnt + 16'd1;
      end
    end
  end
`else
  logic unused_sink;

  assign unused_sink  = ^{m_axi_RRESP, m_axi_RLAST, BURST_LEN[0]};
  assign err_id_cnt   = '0;
  assign err_resp_cnt = '0;
  assign err_last_cnt = '0;
`endif
endmodule

// File: tb/tb_hbm_rdata_demux.sv
// Scoreboard bench for hbm_rdata_demux: randomized R beats, queue-based reference model, decoupled output monitor.
module tb_hbm_rdata_demux;
  localparam int DW = 256;
  localparam int IW = 6;
  localparam int BL = 4;
  localparam int DEPTH = 64;
  localparam logic [IW-1:0] BT = 6'h1;
  localparam logic [IW-1:0] AT = 6'h2;

  logic          hbm_clk, hbm_reset, start, rd_data_done;
  logic [31:0]   expected_beats, beat_cnt;
  logic          m_axi_RVALID, m_axi_RREADY, m_axi_RLAST;
  logic [DW-1:0] m_axi_RDATA, b_data, a_data;
  logic [IW-1:0] m_axi_RID;
  logic [1:0]    m_axi_RRESP;
  logic          b_data_valid, b_data_ready, a_data_valid, a_data_ready;
  logic [15:0]   err_id_cnt, err_resp_cnt, err_last_cnt;

  hbm_rdata_demux #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .B_TAG(BT), .A_TAG(AT),
                    .BURST_LEN(BL), .FIFO_DEPTH(DEPTH)) dut (
    .hbm_clk(hbm_clk), .hbm_reset(hbm_reset), .start(start),
    .expected_beats(expected_beats), .rd_data_done(rd_data_done),
    .m_axi_RVALID(m_axi_RVALID), .m_axi_RREADY(m_axi_RREADY), .m_axi_RDATA(m_axi_RDATA),
    .m_axi_RID(m_axi_RID), .m_axi_RRESP(m_axi_RRESP), .m_axi_RLAST(m_axi_RLAST),
    .b_data_valid(b_data_valid), .b_data_ready(b_data_ready), .b_data(b_data),
    .a_data_valid(a_data_valid), .a_data_ready(a_data_ready), .a_data(a_data),
    .beat_cnt(beat_cnt), .err_id_cnt(err_id_cnt), .err_resp_cnt(err_resp_cnt),
    .err_last_cnt(err_last_cnt)
  );

  initial hbm_clk = 1'b0;
  always #5 hbm_clk = ~hbm_clk;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] d;
    logic [1:0]    resp;
    logic          last;
  } beat_t;

  beat_t         plan[$];
  logic [DW-1:0] qa[$], qb[$];
  int n_vec = 0, n_err = 0;
  int m_beats = 0, m_eid = 0, m_eresp = 0, m_elast = 0, m_pos = 0;
  int n_acc = 0, n_pop_a = 0, n_pop_b = 0;
  bit rnd_rdy = 0, drv_busy = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] eexp(input int v);
`ifdef HBM_RDATA_ERR_CNT_EN
    return (v > 65535) ? 16'hFFFF : 16'(v);
`else
    return (v < 0) ? 16'hFFFF : 16'd0;
`endif
  endfunction

  // Reference model of one accepted beat, stated directly in terms of routing and burst position.
  task automatic model_accept(input beat_t b);
    n_acc++;
    m_beats++;
    if (b.id == BT) qb.push_back(b.d);
    else if (b.id == AT) qa.push_back(b.d);
    else m_eid++;
    if (b.resp != 2'b00) m_eresp++;
    if (b.last != (m_pos == BL - 1)) m_elast++;
    m_pos = (b.last || m_pos == BL - 1) ? 0 : m_pos + 1;
  endtask

  always @(negedge hbm_clk) begin
    if (!hbm_reset) begin
      if (b_data_valid && b_data_ready) begin
        n_pop_b++;
        if (qb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL b_unexpected: got %0h, expected no beat", b_data);
        end else chk("b_data", b_data, qb.pop_front());
      end
      if (a_data_valid && a_data_ready) begin
        n_pop_a++;
        if (qa.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL a_unexpected: got %0h, expected no beat", a_data);
        end else chk("a_data", a_data, qa.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge hbm_clk); #1;
      if (rnd_rdy) begin
        a_data_ready = 1'($urandom_range(0, 1));
        b_data_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic add_burst(input logic [IW-1:0] id, input int len, input int last_at,
                           input int bad_resp_at, input int base);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.id   = id;
      b.d    = (base >= 0) ? DW'(base + i) : rnd_data();
      b.resp = (i == bad_resp_at) ? 2'b10 : 2'b00;
      b.last = (i == last_at);
      plan.push_back(b);
    end
  endtask

  // Entered and left at posedge+1.
  task automatic send_beat(input beat_t b);
    int w = 0;
    m_axi_RVALID = 1'b1; m_axi_RID = b.id; m_axi_RDATA = b.d;
    m_axi_RRESP = b.resp; m_axi_RLAST = b.last;
    forever begin
      @(negedge hbm_clk);
      if (m_axi_RREADY) break;
      w++;
      if (w > 3000) begin
        n_vec++; n_err++;
        $display("FAIL rready_timeout: got RREADY=0 for %0d cycles, expected acceptance", w);
        @(posedge hbm_clk); #1;
        m_axi_RVALID = 1'b0;
        return;
      end
    end
    model_accept(b);
    @(posedge hbm_clk); #1;
    m_axi_RVALID = 1'b0;
  endtask

  task automatic run_plan();
    drv_busy = 1;
    while (plan.size() > 0) send_beat(plan.pop_front());
    drv_busy = 0;
  endtask

  task automatic do_start(input int n);
    @(posedge hbm_clk); #1;
    start = 1'b1; expected_beats = 32'(n);
    m_beats = 0; m_eid = 0; m_eresp = 0; m_elast = 0;
    @(posedge hbm_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge hbm_clk);
      if (rd_data_done) break;
    end
    chk({nm, "_done"}, rd_data_done, 1'b1);
    chk({nm, "_drained"}, {a_data_valid, b_data_valid}, 2'b00);
    chk({nm, "_beat_cnt"}, beat_cnt, 32'(m_beats));
    @(posedge hbm_clk); #1;
  endtask

  task automatic chk_errs(input string nm);
    chk({nm, "_err_id"}, err_id_cnt, eexp(m_eid));
    chk({nm, "_err_resp"}, err_resp_cnt, eexp(m_eresp));
    chk({nm, "_err_last"}, err_last_cnt, eexp(m_elast));
  endtask

  initial begin
    hbm_reset = 1'b1; start = 1'b0; expected_beats = '0;
    m_axi_RVALID = 1'b0; m_axi_RID = '0; m_axi_RDATA = '0; m_axi_RRESP = '0; m_axi_RLAST = 1'b0;
    a_data_ready = 1'b1; b_data_ready = 1'b1;
    repeat (3) @(posedge hbm_clk);
    #1 hbm_reset = 1'b0;
    chk("rst_outputs", {rd_data_done, m_axi_RREADY, a_data_valid, b_data_valid}, 4'b0000);
    chk("rst_beat_cnt", beat_cnt, 32'd0);
    chk("rst_errs", {err_id_cnt, err_resp_cnt, err_last_cnt}, 48'd0);

    // two B bursts with data 0..7
    do_start(8);
    chk("t1_rready", m_axi_RREADY, 1'b1);
    add_burst(BT, 4, 3, -1, 0);
    add_burst(BT, 4, 3, -1, 4);
    run_plan();
    wait_done("t1", 200);
    chk("t1_no_a", n_pop_a, 0);
    chk("t1_b_pops", n_pop_b, 8);

    // interleaved B,A,A,B with random stream backpressure
    do_start(16);
    rnd_rdy = 1;
    add_burst(BT, 4, 3, -1, -1);
    add_burst(AT, 4, 3, -1, -1);
    add_burst(AT, 4, 3, -1, -1);
    add_burst(BT, 4, 3, -1, -1);
    run_plan();
    rnd_rdy = 0;
    @(posedge hbm_clk); #1;
    a_data_ready = 1'b1; b_data_ready = 1'b1;
    wait_done("t2", 500);
    chk_errs("t2");

    // A FIFO fills at exactly DEPTH entries
    a_data_ready = 1'b0;
    do_start(80);
    n_acc = 0; n_pop_a = 0;
    for (int k = 0; k < 20; k++) add_burst(AT, 4, 3, -1, 1000 + 4 * k);
    fork run_plan(); join_none
    for (int i = 0; i < 500 && n_acc < DEPTH; i++) @(negedge hbm_clk);
    repeat (6) @(negedge hbm_clk);
    chk("t3_accepts_full", n_acc, DEPTH);
    chk("t3_rready_low", m_axi_RREADY, 1'b0);
    @(posedge hbm_clk); #1;
    a_data_ready = 1'b1;
    for (int i = 0; i < 2000 && drv_busy; i++) @(posedge hbm_clk);
    #1;
    wait_done("t3", 500);
    chk("t3_a_pops", n_pop_a, 80);

    // unknown RID burst, then A burst with a slave error on beat 2
    do_start(8);
    n_pop_a = 0;
    add_burst(6'h3F, 4, 3, -1, -1);
    add_burst(AT, 4, 3, 1, -1);
    run_plan();
    wait_done("t4", 200);
    chk("t4_a_pops", n_pop_a, 4);
    chk_errs("t4");

    // truncated burst then a clean burst
    do_start(7);
    add_burst(BT, 3, 2, -1, -1);
    run_plan();
    repeat (2) @(negedge hbm_clk);
    chk_errs("t5a");
    @(posedge hbm_clk); #1;
    add_burst(BT, 4, 3, -1, -1);
    run_plan();
    wait_done("t5", 200);
    chk_errs("t5b");

    // random mix of tags, responses and framing faults
    begin
      int tot = 0;
      for (int k = 0; k < 14; k++) begin
        int r = $urandom_range(0, 9);
        logic [IW-1:0] id = (r < 4) ? BT : (r < 8) ? AT : IW'($urandom_range(3, 63));
        int f = $urandom_range(0, 7);
        int len = (f == 0) ? $urandom_range(1, 3) : (f == 1) ? 5 : 4;
        int last_at = (f == 1) ? 4 : len - 1;
        int bad = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1;
        add_burst(id, len, last_at, bad, -1);
        tot += len;
      end
      do_start(tot);
    end
    rnd_rdy = 1;
    run_plan();
    rnd_rdy = 0;
    @(posedge hbm_clk); #1;
    a_data_ready = 1'b1; b_data_ready = 1'b1;
    wait_done("t6", 1000);
    chk_errs("t6");

    // reset with 10 beats buffered
    a_data_ready = 1'b0; b_data_ready = 1'b0;
    do_start(100);
    add_burst(BT, 4, 3, -1, -1);
    add_burst(AT, 4, 3, -1, -1);
    add_burst(BT, 2, 1, -1, -1);
    run_plan();
    chk("t7_buffered", {a_data_valid, b_data_valid}, 2'b11);
    chk("t7_beats_pre", beat_cnt, 32'd10);
    hbm_reset = 1'b1;
    @(posedge hbm_clk); #1;
    hbm_reset = 1'b0;
    qa.delete(); qb.delete();
    m_pos = 0; m_beats = 0; m_eid = 0; m_eresp = 0; m_elast = 0;
    chk("t7_valids", {a_data_valid, b_data_valid}, 2'b00);
    chk("t7_beat_cnt", beat_cnt, 32'd0);
    chk("t7_done", rd_data_done, 1'b0);
    repeat (3) @(negedge hbm_clk);
    chk("t7_rready_idle", m_axi_RREADY, 1'b0);
    @(posedge hbm_clk); #1;
    a_data_ready = 1'b1; b_data_ready = 1'b1;

    // zero-beat run completes one cycle after entering RUN
    do_start(0);
    chk("t8_run", {rd_data_done, m_axi_RREADY}, 2'b01);
    @(posedge hbm_clk); #1;
    chk("t8_done", rd_data_done, 1'b1);
    chk("t8_flushed", {a_data_valid, b_data_valid}, 2'b00);

    repeat (4) @(posedge hbm_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got simulation time limit, expected bench completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hbm_rdata_demux.md
Name: hbm_rdata_demux

Overview:
- Receive end of the HBM AXI read channel: accepts R-channel beats for requests issued by the engine's read-address generator.
- Steers each beat by RID tag into one of two output streams: B (labels) and A (sample features).
- Buffers beats in per-tag FIFOs, checks burst framing and response codes, and flags completion when the programmed beat total has arrived.

Parameters:
- DATA_WIDTH, 256, R-channel and output stream data width.
- ID_WIDTH, 6, RID width.
- B_TAG, 6'h1, RID value that routes to the B stream (equals `MEM_RD_B_TAG).
- A_TAG, 6'h2, RID value that routes to the A stream (equals `MEM_RD_A_TAG).
- BURST_LEN, 4, beats per burst (matches ARLEN=3).
- FIFO_DEPTH, 64, entries per tag FIFO; power of two, at least 4.

Ports:
- hbm_clk  in  1  clock.
- hbm_reset  in  1  synchronous, active-high reset.
- start  in  1  level or pulse; a rising edge arms a run.
- expected_beats  in  32  total R beats (A+B) expected this run; sampled at the start edge.
- rd_data_done  out  1  high from completion until the next start edge.
- m_axi_RVALID  in  1  R valid.
- m_axi_RREADY  out  1  R ready.
- m_axi_RDATA  in  DATA_WIDTH  R data.
- m_axi_RID  in  ID_WIDTH  R id.
- m_axi_RRESP  in  2  R response.
- m_axi_RLAST  in  1  R last.
- b_data_valid  out  1  B stream valid.
- b_data_ready  in  1  B stream ready.
- b_data  out  DATA_WIDTH  B stream data.
- a_data_valid  out  1  A stream valid.
- a_data_ready  in  1  A stream ready.
- a_data  out  DATA_WIDTH  A stream data.
- beat_cnt  out  32  beats accepted this run.
- err_id_cnt  out  16  beats with unknown RID.
- err_resp_cnt  out  16  beats with RRESP != 0.
- err_last_cnt  out  16  framing violations.

Behaviour:
- Reset (synchronous, hbm_reset=1):
  - All outputs 0; FIFOs flushed; state IDLE.
  - Reset mid-run discards buffered beats with no further output.
- Start detection:
  - start is registered and a rising edge is detected.
  - On the edge: latch expected_beats; clear beat_cnt, error counters and rd_data_done.
  - Enter RUN on the next cycle.
- States:
  - IDLE -> RUN on start edge.
  - RUN -> DONE when beat_cnt == latched expected_beats and both FIFOs are empty.
  - DONE holds rd_data_done=1 and returns to RUN on the next start edge.
  - expected_beats=0: RUN -> DONE in one cycle.
- RREADY:
  - m_axi_RREADY = state!=IDLE AND a_count<FIFO_DEPTH AND b_count<FIFO_DEPTH.
  - Driven from registered counts only; no combinational path from RVALID or RID.
  - A pop in the same cycle does not free a slot for that cycle's accept. This is conservative and intended.
- Accept (RVALID & RREADY):
  - RID==B_TAG: push to the B FIFO.
  - RID==A_TAG: push to the A FIFO.
  - Any other RID: drop the beat, err_id_cnt+1.
  - Every accepted beat: beat_cnt+1, including dropped beats.
  - RRESP != 0: data still forwarded, err_resp_cnt+1.
- Framing:
  - One shared beat-in-burst counter 0..BURST_LEN-1 (the read path is in-order, single-ID-at-a-time).
  - RLAST high with counter != BURST_LEN-1: err_last_cnt+1, counter resets.
  - RLAST low with counter == BURST_LEN-1: err_last_cnt+1, counter wraps to 0.
  - Otherwise the counter increments and wraps after BURST_LEN-1.
- FIFOs:
  - First-word-fall-through.
  - Output valid = count != 0; data is the head entry.
  - Pop on valid & ready.
  - Push and pop in the same cycle: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Beats in IDLE: RREADY=0, so none are accepted.
- Beats arriving in DONE are still accepted and counted (beat_cnt may exceed expected_beats).
- Counter widths: error counters saturate at 16'hFFFF; beat_cnt wraps at 2^32.
- Latency: an accepted beat appears on its stream output the next cycle.

Optional Feature:
- Macro: HBM_RDATA_ERR_CNT_EN.
- Defined: RID, RRESP and RLAST checking and the three error counters operate as described.
- Undefined:
  - Checking logic is removed and err_* outputs are tied to 0.
  - Beats with an unknown RID are still dropped and still counted in beat_cnt.

Test Plan:
- Reset then start, expected_beats=8; 2 B-tag bursts of 4 beats, data 0..7, both streams ready -> b_data shows 0..7 in order, no a_data_valid, rd_data_done=1 after the last pop, beat_cnt=8.
- Interleaved bursts: B, A, A, B (16 beats, expected_beats=16) -> each stream receives only its own tag's data, in order; err counters all 0.
- a_data_ready=0, 80 A beats offered, FIFO_DEPTH=64 -> RREADY falls after exactly 64 accepts; set a_data_ready=1 -> all 80 beats delivered in order, none lost or duplicated.
- One burst with RID=6'h3F and one A burst with RRESP=2'b10 on beat 2 -> err_id_cnt=4 and err_resp_cnt=1; the A beats are all forwarded; beat_cnt=8.
- RLAST asserted on beat 3 of a 4-beat burst -> err_last_cnt=1; the next correct burst adds no error.
- hbm_reset pulsed with 10 beats buffered -> both valids 0 the next cycle, beat_cnt=0, state IDLE, RREADY=0 until the next start edge.
